// File: rtl/prescaler_bank.sv
// Bank of N runtime-programmable clock-enable generators sharing one write port.
// New divisors wait in a shadow register and take effect at the channel's next strobe.
module prescaler_bank #(
  parameter int N           = 4,
  parameter int W           = 16,
  parameter int AW          = 2,
  parameter int DEFAULT_DIV = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic [N-1:0]  EN,
  input  logic          SYNC,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [W-1:0]  WDATA,
  output logic [N-1:0]  CEO,
  output logic [N-1:0]  PEND
);

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

  logic [W-1:0] q_q [N];
  logic [W-1:0] q_d [N];
  logic [W-1:0] a_q [N];
  logic [W-1:0] a_d [N];
  logic [W-1:0] s_q [N];
  logic [W-1:0] s_d [N];
  logic [N-1:0] p_q;
  logic [N-1:0] p_d;

  logic [N-1:0] term;
  logic [N-1:0] adv;
  logic [N-1:0] wr_hit;

  always_comb begin
    term   = '0;
    adv    = '0;
    wr_hit = '0;
    CEO    = '0;
    for (int i = 0; i < N; i++) begin
      term[i]   = (q_q[i] >= a_q[i]);
      adv[i]    = CE & EN[i] & ~SYNC;
      // i < N always, so an address match already excludes out-of-range writes
      wr_hit[i] = WE & (WADDR == AW'(i));
      CEO[i]    = adv[i] & term[i];
    end
  end

  assign PEND = p_q;

  always_comb begin
    p_d = p_q;
    for (int i = 0; i < N; i++) begin
      q_d[i] = q_q[i];
      a_d[i] = a_q[i];
      s_d[i] = s_q[i];

      if (SYNC) begin
        q_d[i] = '0;
      end else if (adv[i]) begin
        // Counter clears at terminal count, so it can never pass A and wrap
        q_d[i] = term[i] ? '0 : q_q[i] + 1'b1;
      end

      // SYNC and a strobe both act as apply points for the shadow divisor
      if (wr_hit[i] && (SYNC || CEO[i])) begin
        a_d[i] = WDATA;
        s_d[i] = WDATA;
        p_d[i] = 1'b0;
      end else if (wr_hit[i]) begin
        s_d[i] = WDATA;
        p_d[i] = 1'b1;
      end else if (p_q[i] && (SYNC || CEO[i])) begin
        a_d[i] = s_q[i];
        p_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q <= '0;
      for (int i = 0; i < N; i++) begin
        q_q[i] <= '0;
        a_q[i] <= DEF_DIV;
        s_q[i] <= DEF_DIV;
      end
    end else begin
      p_q <= p_d;
      for (int i = 0; i < N; i++) begin
        q_q[i] <= q_d[i];
        a_q[i] <= a_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Directed bench for prescaler_bank: a 4-channel instance with DEFAULT_DIV=3 and a
// 3-channel instance used to check that out-of-range write addresses are ignored.
module tb_prescaler_bank;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic [3:0]  EN;
  logic        SYNC;
  logic        WE;
  logic [1:0]  WADDR;
  logic [15:0] WDATA;
  logic [3:0]  CEO;
  logic [3:0]  PEND;

  logic [2:0]  en3;
  logic        we3;
  logic [1:0]  waddr3;
  logic [15:0] wdata3;
  logic [2:0]  ceo3;
  logic [2:0]  pend3;

  int n_cmp;
  int n_err;

  logic [3:0] exp_ceo;
  logic [3:0] exp_pend;
  logic [2:0] exp_ceo3;

  prescaler_bank #(.N(4), .W(16), .AW(2), .DEFAULT_DIV(3)) u_dut (
    .CLK(CLK), .RST(RST), .CE(CE), .EN(EN), .SYNC(SYNC), .WE(WE),
    .WADDR(WADDR), .WDATA(WDATA), .CEO(CEO), .PEND(PEND)
  );

  prescaler_bank #(.N(3), .W(16), .AW(2), .DEFAULT_DIV(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .CE(CE), .EN(en3), .SYNC(SYNC), .WE(we3),
    .WADDR(waddr3), .WDATA(wdata3), .CEO(ceo3), .PEND(pend3)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Leaves the bench 1 time unit after a rising edge, in cycle 1 (all Q=0, CE=EN=1).
  task automatic do_reset();
    RST = 1'b1; CE = 1'b1; EN = 4'hF; SYNC = 1'b0;
    WE = 1'b0; WADDR = '0; WDATA = '0;
    en3 = 3'b111; we3 = 1'b0; waddr3 = '0; wdata3 = '0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    #1;
    n_cmp++;
    if (CEO !== 4'h0) begin
      n_err++; $display("FAIL reset_ceo: got %h want %h", CEO, 4'h0);
    end
    n_cmp++;
    if (PEND !== 4'h0) begin
      n_err++; $display("FAIL reset_pend: got %h want %h", PEND, 4'h0);
    end
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      #1;
      exp_ceo = (k % 4 == 0) ? 4'hF : 4'h0;
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL reset_period cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      n_cmp++;
      if (PEND !== 4'h0) begin
        n_err++; $display("FAIL reset_period_pend cyc %0d: got %h want %h", k, PEND, 4'h0);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_glitch_free();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      WE = (k == 5); WADDR = 2'd1; WDATA = 16'd1;
      #1;
      exp_ceo = (k % 4 == 0) ? 4'hF : 4'h0;
      exp_ceo[1] = (k == 4) || (k == 8) || (k > 8 && k % 2 == 0);
      exp_pend = {2'b00, (k >= 6 && k <= 8), 1'b0};
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL glitch_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      n_cmp++;
      if (PEND !== exp_pend) begin
        n_err++; $display("FAIL glitch_pend cyc %0d: got %h want %h", k, PEND, exp_pend);
      end
      @(posedge CLK); #1;
    end
    WE = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      WE = (k == 4); WADDR = 2'd0; WDATA = 16'd5;
      #1;
      exp_ceo = (k % 4 == 0) ? 4'hF : 4'h0;
      exp_ceo[0] = (k == 4) || (k == 10) || (k == 16);
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL collision_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      n_cmp++;
      if (PEND !== 4'h0) begin
        n_err++; $display("FAIL collision_pend cyc %0d: got %h want %h", k, PEND, 4'h0);
      end
      @(posedge CLK); #1;
    end
    WE = 1'b0;
  endtask

  // ch2 gets D=0 pending before SYNC; ch0 is written D=1 in the SYNC cycle itself.
  task automatic test_sync_pending();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      SYNC  = (k == 6);
      WE    = (k == 5) || (k == 6);
      WADDR = (k == 5) ? 2'd2 : 2'd0;
      WDATA = (k == 5) ? 16'd0 : 16'd1;
      #1;
      exp_ceo = ((k == 4) || (k == 10) || (k == 14)) ? 4'hF : 4'h0;
      exp_ceo[2] = (k == 4) || (k >= 7);
      exp_ceo[0] = (k == 4) || (k >= 8 && k % 2 == 0);
      exp_pend = {1'b0, (k == 6), 2'b00};
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL sync_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      n_cmp++;
      if (PEND !== exp_pend) begin
        n_err++; $display("FAIL sync_pend cyc %0d: got %h want %h", k, PEND, exp_pend);
      end
      @(posedge CLK); #1;
    end
    SYNC = 1'b0; WE = 1'b0;
  endtask

  task automatic test_en_gate();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      EN = (k >= 3 && k <= 9) ? 4'h7 : 4'hF;
      #1;
      exp_ceo = (k % 4 == 0) ? 4'hF : 4'h0;
      exp_ceo[3] = (k == 11) || (k == 15);
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL en_gate_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      @(posedge CLK); #1;
    end
    EN = 4'hF;
  endtask

  // CE low for cycles 2..4 with a write to ch1 pending across the stall.
  task automatic test_ce_gate();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      CE = !(k >= 2 && k <= 4);
      WE = (k == 1); WADDR = 2'd1; WDATA = 16'd0;
      #1;
      exp_ceo = ((k == 7) || (k == 11) || (k == 15)) ? 4'hF : 4'h0;
      exp_ceo[1] = (k >= 7);
      exp_pend = {2'b00, (k >= 2 && k <= 7), 1'b0};
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL ce_gate_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      n_cmp++;
      if (PEND !== exp_pend) begin
        n_err++; $display("FAIL ce_gate_pend cyc %0d: got %h want %h", k, PEND, exp_pend);
      end
      @(posedge CLK); #1;
    end
    CE = 1'b1; WE = 1'b0;
  endtask

  task automatic test_illegal_addr();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      we3 = (k == 2) || (k == 4); waddr3 = 2'd3; wdata3 = 16'd0;
      #1;
      exp_ceo3 = (k % 4 == 0) ? 3'b111 : 3'b000;
      n_cmp++;
      if (ceo3 !== exp_ceo3) begin
        n_err++; $display("FAIL illegal_ceo cyc %0d: got %b want %b", k, ceo3, exp_ceo3);
      end
      n_cmp++;
      if (pend3 !== 3'b000) begin
        n_err++; $display("FAIL illegal_pend cyc %0d: got %b want %b", k, pend3, 3'b000);
      end
      @(posedge CLK); #1;
    end
    we3 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      WE = (k == 1); WADDR = 2'd1; WDATA = 16'd0;
      #1;
      if (k < 4) begin
        @(posedge CLK); #1;
      end
    end
    WE = 1'b0;
    #1;
    n_cmp++;
    if (CEO !== 4'hF) begin
      n_err++; $display("FAIL areset_pre_ceo: got %h want %h", CEO, 4'hF);
    end
    n_cmp++;
    if (PEND !== 4'h2) begin
      n_err++; $display("FAIL areset_pre_pend: got %h want %h", PEND, 4'h2);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (CEO !== 4'h0) begin
      n_err++; $display("FAIL areset_ceo: got %h want %h", CEO, 4'h0);
    end
    n_cmp++;
    if (PEND !== 4'h0) begin
      n_err++; $display("FAIL areset_pend: got %h want %h", PEND, 4'h0);
    end
    // Pending write must have been discarded: period stays 4 after release
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      #1;
      exp_ceo = (k % 4 == 0) ? 4'hF : 4'h0;
      n_cmp++;
      if (CEO !== exp_ceo) begin
        n_err++; $display("FAIL areset_after_ceo cyc %0d: got %h want %h", k, CEO, exp_ceo);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_glitch_free();
    test_collision();
    test_sync_pending();
    test_en_gate();
    test_ce_gate();
    test_illegal_addr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
